// File: rtl/digit_edit_ctrl.sv
// Cursor-driven BCD digit editor: snapshot, per-digit wrap, hours-pair limit,
// edge-detected keys with up/down auto-repeat, inactivity timeout, load pulse.
module digit_edit_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter logic [4*NUM_DIGITS-1:0] DIGIT_MAX =
        {4'd2, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9},
    parameter int PAIR_LIMIT   = 1,
    parameter int PAIR_MAX     = 23,
    parameter int BLINK_HALF   = 50_000_000,
    parameter int REPT_DELAY   = 50_000_000,
    parameter int REPT_RATE    = 10_000_000,
    parameter int IDLE_TIMEOUT = 500_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    edit_req,
    input  logic [4*NUM_DIGITS-1:0] cur_val,
    input  logic                    left,
    input  logic                    right,
    input  logic                    up,
    input  logic                    down,
    input  logic                    confirm,
    input  logic                    cancel,
    output logic                    editing,
    output logic [4*NUM_DIGITS-1:0] edit_val,
    output logic [NUM_DIGITS-1:0]   cursor,
    output logic [NUM_DIGITS-1:0]   cursor_blink,
    output logic                    load_valid,
    output logic [4*NUM_DIGITS-1:0] load_val
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int TI = NUM_DIGITS - 1;
    localparam int UI = (NUM_DIGITS >= 2) ? NUM_DIGITS - 2 : 0;
    localparam logic [3:0] T_MAX = 4'(PAIR_MAX / 10);
    localparam logic [3:0] U_MAX = 4'(PAIR_MAX % 10);
    localparam logic [6:0] P_MAX = 7'(PAIR_MAX);
    localparam logic [31:0] BLINK_END = 32'(BLINK_HALF - 1);
    localparam logic [31:0] IDLE_END  = 32'(IDLE_TIMEOUT - 1);
    localparam logic [31:0] RD = 32'(REPT_DELAY);
    localparam logic [31:0] RR = 32'(REPT_RATE);
    localparam logic [NUM_DIGITS-1:0] CUR_RST = {1'b1, {(NUM_DIGITS-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_EDIT, S_COMMIT} state_t;

    state_t                state_q, state_d;
    logic                  editing_q, editing_d;
    logic [W-1:0]          edit_val_q, edit_val_d;
    logic [NUM_DIGITS-1:0] cursor_q, cursor_d;
    logic                  blink_q, blink_d;
    logic [31:0]           blink_cnt_q, blink_cnt_d;
    logic [31:0]           idle_cnt_q, idle_cnt_d;
    logic [31:0]           rept_cnt_q, rept_cnt_d;
    logic                  rept_arm_q, rept_arm_d;
    logic                  rept_first_q, rept_first_d;
    logic                  rept_dn_q, rept_dn_d;
    logic [5:0]            key_q, key_d;
    logic                  load_valid_q, load_valid_d;
    logic [W-1:0]          load_val_q, load_val_d;

    logic [5:0]  keys, edges;
    logic        rept_held, rept_fire, up_ev, dn_ev, accept;
    logic [31:0] rept_next;
    int          idx;
    logic [3:0]  dig, lim, dig_new;
    logic [6:0]  pair_v;

    // key order: confirm, cancel, left, right, up, down (MSB first)
    assign keys  = {confirm, cancel, left, right, up, down};
    assign edges = keys & ~key_q;

    always_comb begin
        rept_held = rept_dn_q ? down : up;
        rept_next = rept_cnt_q + 32'd1;
        rept_fire = 1'b0;
        if (rept_arm_q && rept_held)
            rept_fire = rept_first_q ? (rept_next == RD) : (rept_next == RR);
        up_ev = edges[1] | (rept_fire & ~rept_dn_q);
        dn_ev = edges[0] | (rept_fire & rept_dn_q);

        idx = 0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (cursor_q[i]) idx = i;
        dig = edit_val_q[idx*4 +: 4];
        lim = DIGIT_MAX[idx*4 +: 4];
        if (PAIR_LIMIT != 0) begin
            if (idx == TI)
                lim = T_MAX;
            else if (idx == UI)
                lim = (edit_val_q[TI*4 +: 4] == T_MAX) ? U_MAX : 4'd9;
        end
        // values above the limit wrap to 0 on up
        if (up_ev)
            dig_new = (dig >= lim) ? 4'd0 : dig + 4'd1;
        else
            dig_new = (dig == 4'd0) ? lim : dig - 4'd1;
        pair_v = 7'(dig_new) * 7'd10 + 7'(edit_val_q[UI*4 +: 4]);
    end

    always_comb begin
        state_d      = state_q;
        edit_val_d   = edit_val_q;
        cursor_d     = cursor_q;
        blink_d      = blink_q;
        blink_cnt_d  = blink_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        rept_cnt_d   = rept_cnt_q;
        rept_arm_d   = rept_arm_q;
        rept_first_d = rept_first_q;
        rept_dn_d    = rept_dn_q;
        key_d        = keys;
        load_valid_d = 1'b0;
        load_val_d   = load_val_q;
        accept       = 1'b0;

        case (state_q)
            S_IDLE: begin
                rept_arm_d = 1'b0;
                if (edit_req) begin
                    state_d     = S_EDIT;
                    edit_val_d  = cur_val;
                    cursor_d    = CUR_RST;
                    blink_d     = 1'b1;
                    blink_cnt_d = '0;
                    idle_cnt_d  = '0;
                end
            end
            S_EDIT: begin
                if (blink_cnt_q == BLINK_END) begin
                    blink_cnt_d = '0;
                    blink_d     = ~blink_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 32'd1;
                end
                idle_cnt_d = idle_cnt_q + 32'd1;

                if (edges[1] || edges[0]) begin
                    rept_arm_d   = 1'b1;
                    rept_dn_d    = ~edges[1];
                    rept_cnt_d   = '0;
                    rept_first_d = 1'b1;
                end else if (rept_arm_q && rept_held) begin
                    rept_cnt_d = rept_fire ? '0 : rept_next;
                    if (rept_fire) rept_first_d = 1'b0;
                end else begin
                    rept_arm_d = 1'b0;
                end

                if (edges[5]) begin
                    state_d      = S_COMMIT;
                    load_valid_d = 1'b1;
                    load_val_d   = edit_val_q;
                end else if (edges[4]) begin
                    state_d = S_IDLE;
                end else if (edges[3]) begin
                    cursor_d = {cursor_q[NUM_DIGITS-2:0], cursor_q[NUM_DIGITS-1]};
                    accept   = 1'b1;
                end else if (edges[2]) begin
                    cursor_d = {cursor_q[0], cursor_q[NUM_DIGITS-1:1]};
                    accept   = 1'b1;
                end else if (up_ev || dn_ev) begin
                    edit_val_d[idx*4 +: 4] = dig_new;
                    if (PAIR_LIMIT != 0 && idx == TI && pair_v > P_MAX)
                        edit_val_d[UI*4 +: 4] = U_MAX;
                    accept = 1'b1;
                end else if (idle_cnt_q == IDLE_END) begin
                    state_d = S_IDLE;
                end

                if (accept) begin
                    blink_d     = 1'b1;
                    blink_cnt_d = '0;
                    idle_cnt_d  = '0;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        editing_d = (state_d == S_EDIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            editing_q    <= 1'b0;
            edit_val_q   <= '0;
            cursor_q     <= CUR_RST;
            blink_q      <= 1'b0;
            blink_cnt_q  <= '0;
            idle_cnt_q   <= '0;
            rept_cnt_q   <= '0;
            rept_arm_q   <= 1'b0;
            rept_first_q <= 1'b0;
            rept_dn_q    <= 1'b0;
            key_q        <= '0;
            load_valid_q <= 1'b0;
            load_val_q   <= '0;
        end else begin
            state_q      <= state_d;
            editing_q    <= editing_d;
            edit_val_q   <= edit_val_d;
            cursor_q     <= cursor_d;
            blink_q      <= blink_d;
            blink_cnt_q  <= blink_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            rept_cnt_q   <= rept_cnt_d;
            rept_arm_q   <= rept_arm_d;
            rept_first_q <= rept_first_d;
            rept_dn_q    <= rept_dn_d;
            key_q        <= key_d;
            load_valid_q <= load_valid_d;
            load_val_q   <= load_val_d;
        end
    end

    assign editing      = editing_q;
    assign edit_val     = edit_val_q;
    assign cursor       = cursor_q;
    assign cursor_blink = editing_q ? (cursor_q & {NUM_DIGITS{blink_q}}) : '0;
    assign load_valid   = load_valid_q;
    assign load_val     = load_val_q;

endmodule

// File: tb/tb_digit_edit_ctrl.sv
// Directed bench for digit_edit_ctrl with short blink/repeat/timeout periods.
module tb_digit_edit_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        edit_req;
    logic [23:0] cur_val;
    logic [5:0]  keys;
    logic        editing;
    logic [23:0] edit_val;
    logic [5:0]  cursor;
    logic [5:0]  cursor_blink;
    logic        load_valid;
    logic [23:0] load_val;

    int total = 0;
    int bad   = 0;

    localparam logic [5:0] K_CONF  = 6'b100000;
    localparam logic [5:0] K_CANC  = 6'b010000;
    localparam logic [5:0] K_LEFT  = 6'b001000;
    localparam logic [5:0] K_RIGHT = 6'b000100;
    localparam logic [5:0] K_UP    = 6'b000010;
    localparam logic [5:0] K_DOWN  = 6'b000001;

    always #5 clk = ~clk;

    digit_edit_ctrl #(
        .BLINK_HALF   (3),
        .REPT_DELAY   (4),
        .REPT_RATE    (2),
        .IDLE_TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .edit_req     (edit_req),
        .cur_val      (cur_val),
        .left         (keys[3]),
        .right        (keys[2]),
        .up           (keys[1]),
        .down         (keys[0]),
        .confirm      (keys[5]),
        .cancel       (keys[4]),
        .editing      (editing),
        .edit_val     (edit_val),
        .cursor       (cursor),
        .cursor_blink (cursor_blink),
        .load_valid   (load_valid),
        .load_val     (load_val)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [5:0] k);
        keys = k;
        tick(1);
        keys = '0;
        tick(1);
    endtask

    task automatic enter(input logic [23:0] v);
        cur_val  = v;
        edit_req = 1'b1;
        tick(1);
        edit_req = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        edit_req = 1'b0;
        cur_val  = '0;
        keys     = '0;
        tick(2);
        chk("rst_editing", 32'(editing), 32'd0);
        chk("rst_edit_val", 32'(edit_val), 32'h0);
        chk("rst_cursor", 32'(cursor), 32'b100000);
        chk("rst_blink", 32'(cursor_blink), 32'd0);
        chk("rst_load_valid", 32'(load_valid), 32'd0);
        chk("rst_load_val", 32'(load_val), 32'h0);
        rst_n = 1'b1;
        tick(1);

        // enter and edit
        enter(24'h123456);
        chk("enter_editing", 32'(editing), 32'd1);
        chk("enter_val", 32'(edit_val), 32'h123456);
        chk("enter_cursor", 32'(cursor), 32'b100000);
        chk("enter_blink", 32'(cursor_blink), 32'b100000);
        enter(24'h999999);
        chk("req_ignored", 32'(edit_val), 32'h123456);
        repeat (5) pulse(K_RIGHT);
        chk("right5_cursor", 32'(cursor), 32'b000001);
        pulse(K_UP);
        chk("up_digit0", 32'(edit_val), 32'h123457);
        tick(2);
        chk("blink_off", 32'(cursor_blink), 32'd0);
        tick(3);
        chk("blink_on", 32'(cursor_blink), 32'b000001);
        keys = K_CONF;
        tick(1);
        chk("commit_valid", 32'(load_valid), 32'd1);
        chk("commit_val", 32'(load_val), 32'h123457);
        chk("commit_editing", 32'(editing), 32'd0);
        keys = '0;
        tick(1);
        chk("commit_one_cycle", 32'(load_valid), 32'd0);

        // wrap and pair clamp
        enter(24'h190000);
        pulse(K_UP);
        chk("pair_clamp", 32'(edit_val), 32'h230000);
        pulse(K_UP);
        chk("tens_wrap", 32'(edit_val), 32'h030000);
        keys = K_CANC;
        tick(1);
        chk("cancel_editing", 32'(editing), 32'd0);
        chk("cancel_no_load", 32'(load_valid), 32'd0);
        chk("cancel_keeps_val", 32'(edit_val), 32'h030000);
        keys = '0;
        tick(1);
        chk("cancel_no_load2", 32'(load_valid), 32'd0);

        // cursor wrap and down wrap
        enter(24'h000000);
        pulse(K_LEFT);
        chk("left_wrap", 32'(cursor), 32'b000001);
        pulse(K_DOWN);
        chk("down_wrap", 32'(edit_val), 32'h000009);
        pulse(K_RIGHT);
        chk("right_wrap", 32'(cursor), 32'b100000);
        pulse(K_CANC);

        // auto-repeat then confirm beats up
        enter(24'h000000);
        pulse(K_LEFT);
        keys = K_UP;
        tick(10);
        chk("repeat_count", 32'(edit_val), 32'h000004);
        keys = '0;
        tick(1);
        chk("repeat_release", 32'(edit_val), 32'h000004);
        keys = K_CONF | K_UP;
        tick(1);
        chk("prio_valid", 32'(load_valid), 32'd1);
        chk("prio_val", 32'(load_val), 32'h000004);
        keys = '0;
        tick(1);
        chk("prio_edit_val", 32'(edit_val), 32'h000004);

        // key held on entry, then inactivity timeout
        keys = K_UP;
        enter(24'h000000);
        chk("held_enter", 32'(editing), 32'd1);
        tick(6);
        chk("held_no_event", 32'(edit_val), 32'h000000);
        keys = '0;
        tick(1);
        chk("timeout_not_yet", 32'(editing), 32'd1);
        tick(1);
        chk("timeout_exit", 32'(editing), 32'd0);
        chk("timeout_no_load", 32'(load_valid), 32'd0);

        // asynchronous reset mid-edit
        enter(24'h123456);
        pulse(K_UP);
        chk("pre_reset_val", 32'(edit_val), 32'h223456);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_editing", 32'(editing), 32'd0);
        chk("arst_val", 32'(edit_val), 32'h0);
        chk("arst_cursor", 32'(cursor), 32'b100000);
        chk("arst_blink", 32'(cursor_blink), 32'd0);
        chk("arst_load", 32'(load_valid), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        chk("post_rst_editing", 32'(editing), 32'd0);
        chk("post_rst_load", 32'(load_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digit_edit_ctrl.md
# digit_edit_ctrl

Parametrised cursor-driven digit editor for the clock/timer front end. It snapshots the running time value on request, lets the user move a one-hot cursor and increment/decrement the selected BCD digit with per-digit wrap limits, an optional hours-pair limit, edge-detected keys with auto-repeat, and an inactivity timeout. It returns the edited value through a one-cycle load pulse. It sits between the debounced button block and the timekeeping counters, and drives the display blink mask.

## Interface
- NUM_DIGITS, 6: number of 4-bit BCD digits; digit 0 is least significant.
- DIGIT_MAX, {4'd2,4'd9,4'd5,4'd9,4'd5,4'd9}: packed 4*NUM_DIGITS per-digit maximum, with the MSB digit first.
- PAIR_LIMIT, 1: when 1, digits NUM_DIGITS-1 and NUM_DIGITS-2 form a tens/units pair bounded by PAIR_MAX.
- PAIR_MAX, 23: maximum pair value; must be at most 99.
- BLINK_HALF, 50_000_000: cycles per blink half-period.
- REPT_DELAY, 50_000_000: hold cycles before the first auto-repeat.
- REPT_RATE, 10_000_000: cycles between subsequent auto-repeats.
- IDLE_TIMEOUT, 500_000_000: cycles without a key action before the editor aborts edit mode.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- edit_req  in  1  level; enter edit mode (IDLE only).
- cur_val  in  4*NUM_DIGITS  live time value, sampled on entry.
- left, right, up, down, confirm, cancel  in  1 each  debounced, synchronous levels.
- editing  out  1  high in EDIT.
- edit_val  out  4*NUM_DIGITS  value being edited.
- cursor  out  NUM_DIGITS  one-hot selected digit.
- cursor_blink  out  NUM_DIGITS  blink mask for the display.
- load_valid  out  1  one-cycle pulse carrying the committed value.
- load_val  out  4*NUM_DIGITS  committed value; valid only while load_valid=1.

## Operation
- The controller has three states: IDLE, EDIT and COMMIT.
- **IDLE → EDIT**
  - Triggered by edit_req=1.
  - edit_val ← cur_val; cursor ← one-hot bit NUM_DIGITS-1; blink phase ← 1; timeout counter cleared.
- **Key events in EDIT**
  - A key event is the rising edge of a key: the current sample is 1 and the registered previous sample is 0.
  - An auto-repeat also counts as a key event. Auto-repeat applies only to up and down, after REPT_DELAY cycles of continuous hold, then every REPT_RATE cycles while held.
- **Event priority** (one action per cycle): confirm > cancel > left > right > up > down. Lower-priority events in the same cycle are discarded.
- **Cursor moves**
  - left rotates toward the MSB: bit NUM_DIGITS-1 wraps to bit 0.
  - right rotates toward the LSB: bit 0 wraps to bit NUM_DIGITS-1.
- **Digit up/down** act only on the digit under the cursor, using that digit's limit M:
  - up: d==M → 0, else d+1.
  - down: d==0 → M, else d-1.
  - Digit values above M (from a snapshot) are treated as M+1 for up, wrapping to 0.
- **Pair limit** (PAIR_LIMIT=1)
  - Tens limit = PAIR_MAX/10.
  - Units limit = PAIR_MAX%10 when tens==PAIR_MAX/10, else 9.
  - A tens change that makes tens*10+units exceed PAIR_MAX clamps units to PAIR_MAX%10 in the same update.
- **Blink and timeout restart:** every accepted key event restarts the blink phase at 1 and clears the timeout counter.
- **Leaving EDIT**
  - confirm → COMMIT.
  - cancel, or the timeout counter reaching IDLE_TIMEOUT-1 → IDLE; edit_val is kept and no load occurs.
- **COMMIT:** load_valid=1 and load_val=edit_val for exactly one cycle, then IDLE unconditionally.
- **Blink mask:** cursor_blink = editing ? (cursor & {NUM_DIGITS{blink_phase}}) : 0. blink_phase toggles every BLINK_HALF cycles while in EDIT.

## Timing
- Reset values: state IDLE; editing=0; edit_val=0; load_val=0; load_valid=0; cursor=1<<(NUM_DIGITS-1); cursor_blink=0; blink and repeat counters 0; previous key samples 0.
- The reset is asynchronous on assertion. Deassertion takes effect at the next clk edge.
- All outputs are registered except cursor_blink, which is combinational from registers.
- Latency from edit_req to editing=1 and the snapshot visible is one cycle. A key edge updates edit_val or cursor one cycle later.
- Confirm to load_valid takes one cycle. editing falls on the same edge that load_valid rises.
- A key held when entering EDIT produces no event until it is released and pressed again.
- edit_req while in EDIT or COMMIT is ignored.
- cur_val changes during EDIT are ignored.
- Reset during EDIT discards the edit; no load_valid is generated.

## Test plan
- **Enter and edit:** rst_n pulse, cur_val=12_34_56, edit_req=1 → next cycle editing=1, edit_val=123456, cursor=6'b100000. Then right×5, up → cursor=6'b000001, edit_val=123457.
- **Wrap and pair clamp:** snapshot 19_00_00; cursor on MSB; up → 29 clamps to 23, so edit_val=230000. Then up → 030000. Then down on digit 0 of 000000 → 000009.
- **Cursor wrap:** left from 6'b100000 → 6'b000001; right from 6'b000001 → 6'b100000.
- **Commit and cancel:** confirm → load_valid=1 for exactly one cycle, load_val=edit_val, editing=0. A separate run using cancel → no load_valid pulse.
- **Auto-repeat and priority:** with REPT_DELAY=4 and REPT_RATE=2, hold up for 10 cycles on digit 0 from 0 → events at the press edge, delay+4 and every 2 cycles after, giving digit=4. confirm and up in the same cycle → commit only, with no increment.
- **Timeout and reset:** with IDLE_TIMEOUT=8, no keys → editing=0 after 8 cycles and no load. Asserting rst_n low mid-edit → all outputs at their reset values immediately.
